// File: rtl/bf16_norm_arbiter.sv
// bf16_norm_arbiter: two-requester arbiter feeding a shared 2-stage leading-zero/normalise pipeline.
// Define NORM_ARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module bf16_norm_arbiter #(
    parameter int W = 16,
    parameter int E_W = 8,
    localparam int CNT_W = $clog2(W + 1)
) (
    input  logic             clk,
    input  logic             nreset,
    input  logic [1:0]       req_valid_i,
    output logic [1:0]       req_ready_o,
    input  logic [2*W-1:0]   req_mant_i,
    input  logic [2*E_W-1:0] req_exp_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic             out_id_o,
    output logic [W-1:0]     out_mant_o,
    output logic [E_W-1:0]   out_exp_o,
    output logic             out_zero_o,
    output logic             out_uf_o
);
    logic             r_s1_valid;
    logic             r_s1_id;
    logic [W-1:0]     r_s1_mant;
    logic [E_W-1:0]   r_s1_exp;
    logic [CNT_W-1:0] r_s1_cnt;
    logic             w_s1_adv;
    logic             w_s2_adv;
    logic             w_gnt1;
    logic [W-1:0]     w_mant;
    logic [E_W-1:0]   w_exp;
    logic [CNT_W-1:0] w_cnt;
    logic             w_uf;
    logic             w_norm;

    assign w_s2_adv = ~out_valid_o | out_ready_i;
    assign w_s1_adv = ~r_s1_valid | w_s2_adv;

`ifdef NORM_ARB_RR_EN
    logic r_ptr;
    assign w_gnt1 = req_valid_i[1] & (~req_valid_i[0] | r_ptr);
    always_ff @(posedge clk or negedge nreset)
        if (!nreset) r_ptr <= 1'b0;
        else if (|req_ready_o) r_ptr <= ~w_gnt1;
`else
    assign w_gnt1 = req_valid_i[1] & ~req_valid_i[0];
`endif

    assign req_ready_o = {w_gnt1, req_valid_i[0] & ~w_gnt1} & {2{w_s1_adv}};
    assign w_mant      = w_gnt1 ? req_mant_i[2*W-1:W] : req_mant_i[W-1:0];
    assign w_exp       = w_gnt1 ? req_exp_i[2*E_W-1:E_W] : req_exp_i[E_W-1:0];

    // Scan upward so the highest set bit sets the final count
    always_comb begin
        w_cnt = CNT_W'(W);
        for (int i = 0; i < W; i++)
            if (w_mant[i]) w_cnt = CNT_W'(W - 1 - i);
    end

    always_ff @(posedge clk or negedge nreset)
        if (!nreset) begin
            r_s1_valid <= 1'b0;
            r_s1_id    <= 1'b0;
            r_s1_mant  <= '0;
            r_s1_exp   <= '0;
            r_s1_cnt   <= '0;
        end else if (w_s1_adv) begin
            r_s1_valid <= |req_ready_o;
            r_s1_id    <= w_gnt1;
            r_s1_mant  <= w_mant;
            r_s1_exp   <= w_exp;
            r_s1_cnt   <= w_cnt;
        end

    assign w_uf   = {1'b0, r_s1_exp} <= (E_W + 1)'(r_s1_cnt);
    assign w_norm = |r_s1_mant & ~w_uf;

    always_ff @(posedge clk or negedge nreset)
        if (!nreset) begin
            out_valid_o <= 1'b0;
            out_id_o    <= 1'b0;
            out_mant_o  <= '0;
            out_exp_o   <= '0;
            out_zero_o  <= 1'b0;
            out_uf_o    <= 1'b0;
        end else if (w_s2_adv) begin
            out_valid_o <= r_s1_valid;
            out_id_o    <= r_s1_id;
            out_mant_o  <= w_norm ? r_s1_mant << r_s1_cnt : '0;
            out_exp_o   <= w_norm ? r_s1_exp - E_W'(r_s1_cnt) : '0;
            out_zero_o  <= ~|r_s1_mant;
            out_uf_o    <= |r_s1_mant & w_uf;
        end
endmodule

// File: tb/tb_bf16_norm_arbiter.sv
// tb_bf16_norm_arbiter: directed checks of arbitration, normalisation, backpressure and reset.
module tb_bf16_norm_arbiter;
`ifdef NORM_ARB_RR_EN
    localparam bit RR = 1'b1;
`else
    localparam bit RR = 1'b0;
`endif
    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic [1:0]  req_valid_i;
    logic [1:0]  req_ready_o;
    logic [31:0] req_mant_i;
    logic [15:0] req_exp_i;
    logic        out_valid_o;
    logic        out_ready_i;
    logic        out_id_o;
    logic [15:0] out_mant_o;
    logic [7:0]  out_exp_o;
    logic        out_zero_o;
    logic        out_uf_o;
    logic [31:0] w_out;
    int          n_chk = 0;
    int          n_fail = 0;

    always #5 clk = ~clk;

    bf16_norm_arbiter #(.W(16), .E_W(8)) dut (
        .clk(clk), .nreset(nreset),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
        .req_mant_i(req_mant_i), .req_exp_i(req_exp_i),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
        .out_id_o(out_id_o), .out_mant_o(out_mant_o), .out_exp_o(out_exp_o),
        .out_zero_o(out_zero_o), .out_uf_o(out_uf_o)
    );

    assign w_out = {4'b0, out_valid_o, out_id_o, out_mant_o, out_exp_o, out_zero_o, out_uf_o};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] res(input logic id, input logic [15:0] m, input logic [7:0] e,
                                        input logic z, input logic u);
        return {4'b0, 1'b1, id, m, e, z, u};
    endfunction

    function automatic logic [31:0] cont_res(input int j);
        logic id;
        id = RR && (j % 2 == 1);
        return res(id, 16'h8000, id ? 8'd4 : 8'd5, 1'b0, 1'b0);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic [15:0] m, input logic [7:0] e);
        req_mant_i[15:0] = m;
        req_exp_i[7:0]   = e;
    endtask

    task automatic set1(input logic [15:0] m, input logic [7:0] e);
        req_mant_i[31:16] = m;
        req_exp_i[15:8]   = e;
    endtask

    initial begin
        req_valid_i = 2'b00;
        req_mant_i  = '0;
        req_exp_i   = '0;
        out_ready_i = 1'b1;
        tick;
        tick;
        chk("reset_out", w_out, 32'd0);
        nreset = 1'b1;
        tick;
        // single request: 0x0123 has 7 leading zeros
        set0(16'h0123, 8'd20);
        req_valid_i = 2'b01;
        #1;
        chk("single_ready", 32'(req_ready_o), 32'd1);
        tick;
        req_valid_i = 2'b00;
        chk("single_latency", 32'(out_valid_o), 32'd0);
        tick;
        chk("single_out", w_out, res(1'b0, 16'h9180, 8'd13, 1'b0, 1'b0));
        tick;
        chk("single_drain", 32'(out_valid_o), 32'd0);
        // zero, underflow and smallest normal result, back to back
        set0(16'h0000, 8'd50);
        req_valid_i = 2'b01;
        tick;
        set0(16'h0001, 8'd15);
        tick;
        chk("zero", w_out, res(1'b0, 16'h0000, 8'd0, 1'b1, 1'b0));
        set1(16'h0001, 8'd16);
        req_valid_i = 2'b10;
        tick;
        chk("underflow", w_out, res(1'b0, 16'h0000, 8'd0, 1'b0, 1'b1));
        req_valid_i = 2'b00;
        tick;
        chk("min_normal", w_out, res(1'b1, 16'h8000, 8'd1, 1'b0, 1'b0));
        tick;
        chk("batch_drain", 32'(out_valid_o), 32'd0);
        // contention for four cycles
        set0(16'h8000, 8'd5);
        set1(16'h4000, 8'd5);
        req_valid_i = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("cont_ready", 32'(req_ready_o), (RR && (i % 2 == 1)) ? 32'd2 : 32'd1);
            tick;
            if (i > 0) chk("cont_out", w_out, cont_res(i - 1));
        end
        req_valid_i = 2'b00;
        tick;
        chk("cont_out_last", w_out, cont_res(3));
        tick;
        chk("cont_drain", 32'(out_valid_o), 32'd0);
        // backpressure: two accepts then stall, then simultaneous pop and accept
        out_ready_i = 1'b0;
        set0(16'h0100, 8'd30);
        req_valid_i = 2'b01;
        #1;
        chk("bp_ready0", 32'(req_ready_o), 32'd1);
        tick;
        set0(16'h0100, 8'd31);
        #1;
        chk("bp_ready1", 32'(req_ready_o), 32'd1);
        tick;
        set0(16'h0100, 8'd32);
        #1;
        chk("bp_full_ready", 32'(req_ready_o), 32'd0);
        chk("bp_head", w_out, res(1'b0, 16'h8000, 8'd23, 1'b0, 1'b0));
        tick;
        chk("bp_hold", w_out, res(1'b0, 16'h8000, 8'd23, 1'b0, 1'b0));
        chk("bp_hold_ready", 32'(req_ready_o), 32'd0);
        out_ready_i = 1'b1;
        #1;
        chk("pop_accept_ready", 32'(req_ready_o), 32'd1);
        tick;
        chk("pop_accept_out", w_out, res(1'b0, 16'h8000, 8'd24, 1'b0, 1'b0));
        set0(16'h0100, 8'd33);
        tick;
        chk("bp_out_c", w_out, res(1'b0, 16'h8000, 8'd25, 1'b0, 1'b0));
        req_valid_i = 2'b00;
        tick;
        chk("bp_out_d", w_out, res(1'b0, 16'h8000, 8'd26, 1'b0, 1'b0));
        tick;
        chk("bp_drain", 32'(out_valid_o), 32'd0);
        // reset with both stages full
        out_ready_i = 1'b0;
        set0(16'h0100, 8'd40);
        req_valid_i = 2'b01;
        tick;
        set0(16'h0100, 8'd41);
        tick;
        req_valid_i = 2'b00;
        chk("pre_reset_full", 32'(out_valid_o), 32'd1);
        #2;
        nreset = 1'b0;
        #1;
        chk("reset_async", w_out, 32'd0);
        tick;
        nreset = 1'b1;
        out_ready_i = 1'b1;
        // 0x0010 has 11 leading zeros
        set1(16'h0010, 8'd20);
        req_valid_i = 2'b10;
        #1;
        chk("post_reset_req1_ready", 32'(req_ready_o), 32'd2);
        tick;
        req_valid_i = 2'b00;
        tick;
        chk("post_reset_req1_out", w_out, res(1'b1, 16'h8000, 8'd9, 1'b0, 1'b0));
        // pointer returns to 0 on reset after a requester-0 accept
        set0(16'h8000, 8'd7);
        req_valid_i = 2'b01;
        tick;
        req_valid_i = 2'b00;
        nreset = 1'b0;
        #2;
        nreset = 1'b1;
        req_valid_i = 2'b11;
        #1;
        chk("reset_pointer", 32'(req_ready_o), 32'd1);
        tick;
        req_valid_i = 2'b00;
        tick;
        chk("reset_pointer_out", w_out, res(1'b0, 16'h8000, 8'd7, 1'b0, 1'b0));
        tick;
        chk("final_drain", 32'(out_valid_o), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/bf16_norm_arbiter.md
Name: bf16_norm_arbiter

Overview:
- Shares one leading-zero-count and normalisation datapath between two BFloat16 arithmetic units (e.g. adder and multiplier).
- Each unit presents an unnormalised extended mantissa and biased exponent.
- The block arbitrates between them, counts leading zeros, shifts the mantissa left and adjusts the exponent.
- Results return on one tagged output port, through a 2-stage valid/ready pipeline with full throughput.

Parameters:
- W, 16: extended mantissa width (hidden bit, fraction, guard bits); power of 2, at least 4.
- E_W, 8: biased exponent width.
- CNT_W, $clog2(W+1): leading-zero count width; derived, not overridable.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- nreset  input  1  asynchronous active-low reset.
- req_valid_i  input  2  per-requester valid; bit k is requester k.
- req_ready_o  output  2  per-requester ready.
- req_mant_i  input  2*W  mantissas; requester k in bits [k*W +: W].
- req_exp_i  input  2*E_W  biased exponents; requester k in bits [k*E_W +: E_W].
- out_valid_o  output  1  normalised result valid.
- out_ready_i  input  1  downstream ready.
- out_id_o  output  1  index of the requester owning the result.
- out_mant_o  output  W  normalised mantissa; MSB is 1 unless zero or underflow.
- out_exp_o  output  E_W  adjusted exponent.
- out_zero_o  output  1  input mantissa was zero.
- out_uf_o  output  1  exponent underflow; result flushed to zero.

Behaviour:
- Reset: asynchronous on nreset low. S1/S2 valid = 0; out_valid_o = 0; out_id_o, out_mant_o, out_exp_o, out_zero_o, out_uf_o = 0; priority pointer = 0.
- Handshake: a transfer occurs when valid and ready are both high on a rising edge.
  - Requesters hold valid, mantissa and exponent stable until accepted.
  - Downstream holds ready independent of out_valid_o.
- Arbitration (combinational):
  - grant = requester with valid set. If both are valid, grant = pointer.
  - req_ready_o[k] = grant[k] & s1_adv. At most one bit is high.
  - req_ready_o depends on req_valid_i; no combinational path from req_valid_i to out_*.
- Pointer: after an accepted transfer from requester k, pointer = ~k. It is unchanged when nothing is accepted.
- Stage S1 (accept edge):
  - Registers id, mantissa and exponent of the granted requester.
  - Also registers cnt = number of leading zeros of that mantissa, computed combinationally in the same cycle; cnt = W when the mantissa is 0.
- Stage S2 (next edge): registers the result, computed from S1 as:
  - mantissa == 0: mant = 0, exp = 0, zero = 1, uf = 0.
  - else if exp <= cnt (compare at E_W+1 bits unsigned): mant = 0, exp = 0, zero = 0, uf = 1.
  - else: mant = mantissa << cnt (W bits, zeros shifted in), exp = exp - cnt, zero = 0, uf = 0.
- S2 drives out_* directly from its registers.
- Flow control:
  - s2_adv = ~out_valid_o | out_ready_i.
  - s1_adv = ~s1_valid | s2_adv.
  - S1 loads on s1_adv; S2 loads on s2_adv and takes S1's valid.
  - A stalled stage holds all of its data.
- Latency: accept at edge N gives out_valid_o high after edge N+1 (2 cycles). Throughput is one result per cycle while out_ready_i = 1.
- Backpressure: with out_ready_i low, the pipeline fills after 2 accepts, then req_ready_o = 0. No result is dropped or duplicated.
- Simultaneous events: an output pop and a requester accept on the same edge are legal. S2 takes S1 while S1 takes the new request.
- Reset mid-operation: in-flight results are discarded and the pointer returns to 0. Requesters re-present after reset.

Optional Feature:
- Macro: NORM_ARB_RR_EN.
- Defined: round-robin pointer as specified above.
- Undefined: fixed priority. Requester 0 always wins on conflict; the pointer register is not implemented.
- All other behaviour is identical in both builds.

Test Plan:
- Single request, W=16: req0 mant=16'h0123, exp=8'd20 -> 2 cycles later out_valid_o=1, id=0, mant=16'h9180, exp=8'd13, zero=0, uf=0.
- Zero and underflow:
  - mant=16'h0000, exp=8'd50 -> mant=0, exp=0, zero=1.
  - mant=16'h0001, exp=8'd15 (cnt=15) -> uf=1, mant=0, exp=0.
  - mant=16'h0001, exp=8'd16 -> mant=16'h8000, exp=8'd1.
- Contention: both requesters valid for 4 cycles, out_ready_i=1.
  - Round-robin build: accepted ids 0,1,0,1.
  - Fixed-priority build: 0,0,0,0 with req_ready_o[1]=0.
- Backpressure: out_ready_i=0 with continuous req0 traffic -> exactly 2 accepts, then req_ready_o=0. Raise out_ready_i -> results come out in order with none lost; then one accept per cycle.
- Simultaneous pop/accept: pipeline full, out_ready_i and req_valid_i high on the same edge -> one output retires, one request accepted, ordering preserved.
- Reset mid-stream: assert nreset low with both stages valid -> out_valid_o=0 immediately (asynchronous), pointer=0. After release, req1-only traffic is accepted on the first cycle.
